// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package prog_delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a delay value able to hold 0..max_delay.
    function automatic int delay_width(int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Requested delay forced into the legal range 1..max_delay.
    function automatic int clamp_delay(int sel, int max_delay);
        if (sel < 1) begin
            return 1;
        end
        if (sel > max_delay) begin
            return max_delay;
        end
        return sel;
    endfunction

endpackage

// File: rtl/delay_shift_reg.sv
// History shift register with valid bits, a synchronous valid-clear and a
// combinational tap. Tap select 0 is the live input; select n is stage n-1.
// The output register in the top level supplies the final stage, so DEPTH
// registered stages here give delays up to DEPTH+1.
module delay_shift_reg #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 15,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic [SEL_W-1:0]  sel,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_data
);

    logic [DATA_W-1:0] data_q  [DEPTH];
    logic              valid_q [DEPTH];

    // Shift every cycle; clear drops every stored valid but the incoming one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= clear ? 1'b0 : valid_q[i-1];
            end
        end
    end

    // Tap mux; a stage read during a clear is treated as already invalid.
    always_comb begin
        tap_data  = in_data;
        tap_valid = in_valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(sel) == i + 1) begin
                tap_data  = data_q[i];
                tap_valid = valid_q[i] & ~clear;
            end
        end
    end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel delay line with runtime-selectable latency 1..MAX_DELAY.
// Optional per-channel output inversion is enabled by defining DELAY_INVERT_EN.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int CHANNELS      = 2,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [CHANNELS*WIDTH-1:0]           in_data,
    input  logic                                delay_load,
    input  logic [delay_width(MAX_DELAY)-1:0]   delay_sel,
    input  logic [CHANNELS-1:0]                 invert_mask,
    output logic                                out_valid,
    output logic [CHANNELS*WIDTH-1:0]           out_data,
    output logic                                busy,
    output logic [delay_width(MAX_DELAY)-1:0]   cur_delay
);

    localparam int DW  = delay_width(MAX_DELAY);
    localparam int TOT = CHANNELS * WIDTH;
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

    state_t          state, state_nxt;
    logic [DW-1:0]   fill_cnt, fill_cnt_nxt;
    logic [DW-1:0]   new_delay, eff_delay, tap_sel;
    logic            tap_valid;
    logic [TOT-1:0]  tap_data, shaped_data;

    assign new_delay = DW'(clamp_delay(int'(delay_sel), MAX_DELAY));
    // The load edge already taps with the new delay so a coincident sample
    // (including D=1, straight into the output register) keeps its place.
    assign eff_delay = delay_load ? new_delay : cur_delay;
    assign tap_sel   = eff_delay - DW'(1);

    delay_shift_reg #(
        .DATA_W (TOT),
        .DEPTH  (MAX_DELAY - 1),
        .SEL_W  (DW)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (delay_load),
        .sel       (tap_sel),
        .tap_valid (tap_valid),
        .tap_data  (tap_data)
    );

`ifdef DELAY_INVERT_EN
    logic [TOT-1:0] inv_bits;

    // Expand the live per-channel mask to full channel width.
    always_comb begin
        inv_bits = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            inv_bits[c*WIDTH +: WIDTH] = {WIDTH{invert_mask[c]}};
        end
    end

    assign shaped_data = tap_data ^ inv_bits;
`else
    logic unused_invert_mask;

    assign unused_invert_mask = ^invert_mask;
    assign shaped_data        = tap_data;
`endif

    // Output register: last stage of the delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= tap_valid;
            out_data  <= shaped_data;
        end
    end

    // State register, fill counter and delay in effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            fill_cnt  <= '0;
            cur_delay <= DEF_D;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
            if (delay_load) begin
                cur_delay <= new_delay;
            end
        end
    end

    // Next-state: a load always restarts the fill.
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        if (delay_load) begin
            state_nxt    = FILL;
            fill_cnt_nxt = '0;
        end else begin
            case (state)
                FILL: begin
                    if (fill_cnt == cur_delay - DW'(1)) begin
                        state_nxt = RUN;
                    end else begin
                        fill_cnt_nxt = fill_cnt + DW'(1);
                    end
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = FILL;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state == FILL);
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line (WIDTH=1, CHANNELS=2, MAX_DELAY=16,
// DEFAULT_DELAY=4). Define DELAY_INVERT_EN to exercise output inversion.
module tb_prog_delay_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_data;
    logic       delay_load;
    logic [4:0] delay_sel;
    logic [1:0] invert_mask;
    logic       out_valid;
    logic [1:0] out_data;
    logic       busy;
    logic [4:0] cur_delay;

    prog_delay_line #(
        .WIDTH         (1),
        .CHANNELS      (2),
        .MAX_DELAY     (16),
        .DEFAULT_DELAY (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .delay_load  (delay_load),
        .delay_sel   (delay_sel),
        .invert_mask (invert_mask),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .cur_delay   (cur_delay)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] d;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   edge_n  = 0;
    int   model_d = 4;
    int   total   = 0;
    int   bad     = 0;

    always @(posedge clk) edge_n++;

    function automatic int tb_clamp(int s);
        if (s == 0)  return 1;
        if (s > 16)  return 16;
        return s;
    endfunction

    function automatic logic [1:0] inv_model();
`ifdef DELAY_INVERT_EN
        return invert_mask;
`else
        return 2'b00;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive one edge; afterwards update the expected-output model.
    task automatic cyc(input logic v, input logic [1:0] d, input logic ld, input logic [4:0] sel);
        exp_t keep[$];
        exp_t n;
        in_valid   = v;
        in_data    = d;
        delay_load = ld;
        delay_sel  = sel;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            model_d = 4;
        end else begin
            if (ld) begin
                foreach (q[i]) if (q[i].due < edge_n) keep.push_back(q[i]);
                q = keep;
                model_d = tb_clamp(int'(sel));
            end
            if (v) begin
                n.d   = d ^ inv_model();
                n.due = edge_n + model_d - 1;
                q.push_back(n);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 2'b00, 1'b0, 5'd0);
    endtask

    task automatic wait_idle(input int exp_len);
        int n = 0;
        while (busy && n < 100) begin
            idle(1);
            n++;
        end
        check("busy_len", n, exp_len);
    endtask

    // Monitor: every out_valid must match the oldest expected sample and its cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid actual data=%0d at edge %0d required=no output", out_data, edge_n);
            end else begin
                e = q.pop_front();
                if (out_data !== e.d || edge_n != e.due) begin
                    bad++;
                    $display("FAIL sample actual data=%0d edge=%0d required data=%0d edge=%0d",
                             out_data, edge_n, e.d, e.due);
                end
            end
        end else begin
            while (q.size() > 0 && q[0].due <= edge_n) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_sample actual=no output required data=%0d edge=%0d", e.d, e.due);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        invert_mask = 2'b00;
        idle(3);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_cur_delay", int'(cur_delay), 4);
        rst = 1'b0;
        wait_idle(4);

        // Impulse at D=3
        cyc(1'b0, 2'b00, 1'b1, 5'd3);
        check("load3_cur_delay", int'(cur_delay), 3);
        check("load3_busy", int'(busy), 1);
        wait_idle(3);
        cyc(1'b1, 2'b10, 1'b0, 5'd0);
        idle(6);

        // Counter stream at D=4, switch to D=2 with a coincident sample
        cyc(1'b0, 2'b00, 1'b1, 5'd4);
        wait_idle(4);
        for (int i = 0; i < 12; i++) cyc(1'b1, 2'(i), 1'b0, 5'd0);
        cyc(1'b1, 2'(12), 1'b1, 5'd2);
        check("chg_cur_delay", int'(cur_delay), 2);
        check("chg_busy0", int'(busy), 1);
        cyc(1'b1, 2'(13), 1'b0, 5'd0);
        check("chg_busy1", int'(busy), 1);
        cyc(1'b1, 2'(14), 1'b0, 5'd0);
        check("chg_busy2", int'(busy), 0);
        for (int i = 15; i < 23; i++) cyc(1'b1, 2'(i), 1'b0, 5'd0);
        idle(6);

        // Clamp low: D=1
        cyc(1'b0, 2'b00, 1'b1, 5'd0);
        check("clamp_lo", int'(cur_delay), 1);
        wait_idle(1);
        cyc(1'b1, 2'b11, 1'b0, 5'd0);
        cyc(1'b1, 2'b01, 1'b0, 5'd0);
        cyc(1'b1, 2'b10, 1'b0, 5'd0);
        cyc(1'b1, 2'b00, 1'b0, 5'd0);
        idle(3);

        // Clamp high: D=16
        cyc(1'b0, 2'b00, 1'b1, 5'd31);
        check("clamp_hi", int'(cur_delay), 16);
        wait_idle(16);
        cyc(1'b1, 2'b01, 1'b0, 5'd0);
        cyc(1'b1, 2'b10, 1'b0, 5'd0);
        cyc(1'b1, 2'b11, 1'b0, 5'd0);
        idle(18);

        // Inversion (channel 0 only)
        invert_mask = 2'b01;
        cyc(1'b1, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 2'b11, 1'b0, 5'd0);
        idle(18);
        invert_mask = 2'b00;

        // Reset with samples in flight
        cyc(1'b1, 2'b01, 1'b0, 5'd0);
        cyc(1'b1, 2'b10, 1'b0, 5'd0);
        cyc(1'b1, 2'b11, 1'b0, 5'd0);
        idle(2);
        rst = 1'b1;
        idle(2);
        check("rst2_cur_delay", int'(cur_delay), 4);
        check("rst2_busy", int'(busy), 1);
        check("rst2_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        cyc(1'b1, 2'b10, 1'b0, 5'd0);
        cyc(1'b1, 2'b01, 1'b0, 5'd0);
        cyc(1'b1, 2'b11, 1'b0, 5'd0);
        idle(8);

        n = 0;
        while (q.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        check("drain_left", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
